// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator. It derives a pixel tick from the
//   system clock, runs horizontal/vertical counters and decodes sync and blank
//   for any video mode described by the parameters. It also provides line and
//   frame start strobes, configurable sync polarity, and a delay line that
//   keeps sync/blank aligned with a downstream pixel pipeline. A run/stop FSM
//   stops only at a frame boundary, so a stop request never truncates a frame.
//
// Ports
//   i_clk          system clock
//   i_reset_n      asynchronous reset, active-low
//   i_enable       1 = run; 0 = stop at the end of the current frame
//   o_tick         pixel-tick strobe, one clock wide
//   o_x, o_y       horizontal / vertical counters
//   o_video_on     inside the visible area (delayed PIPE_DLY clocks)
//   o_hsync        horizontal sync (delayed PIPE_DLY clocks)
//   o_vsync        vertical sync (delayed PIPE_DLY clocks)
//   o_line_start   strobe on the tick where o_x == 0 (RUN only)
//   o_frame_start  strobe on the tick where o_x == 0 and o_y == 0 (RUN only)
//   o_running      FSM is in RUN
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PIPE_DLY = 0,
  parameter int COORD_W  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  output logic               o_tick,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_video_on,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_line_start,
  output logic               o_frame_start,
  output logic               o_running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Elaboration-time sanity checks on the mode description.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..15");
  end
  if (((H_TOTAL - 1) >> COORD_W) != 0 || ((V_TOTAL - 1) >> COORD_W) != 0) begin : g_bad_w
    $error("vga_timing_gen: COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);

  // Decode thresholds are one bit wider than the counters so that a sync
  // region ending exactly at H_TOTAL/V_TOTAL does not wrap to zero.
  localparam logic [COORD_W:0] H_VIS    = (COORD_W+1)'(H_ACTIVE);
  localparam logic [COORD_W:0] H_SYNC_S = (COORD_W+1)'(H_ACTIVE + H_FP);
  localparam logic [COORD_W:0] H_SYNC_E = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W:0] V_VIS    = (COORD_W+1)'(V_ACTIVE);
  localparam logic [COORD_W:0] V_SYNC_S = (COORD_W+1)'(V_ACTIVE + V_FP);
  localparam logic [COORD_W:0] V_SYNC_E = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               run;
  logic               vid_c, hs_c, vs_c;

  // ---------------------------------------------------------------------------
  // Pixel-tick divider: free-running in every state; o_tick is registered so
  // it is high during the clock after the divider reaches its last count.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= (div_q == DIV_MAX);
      div_q  <= (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Run/stop FSM and raster counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (o_tick) begin
      unique case (state_q)
        S_IDLE: begin
          // Counters are already 0 here: RUN is only left at the frame wrap.
          if (i_enable) state_d = S_RUN;
        end
        S_RUN: begin
          if (x_q == H_LAST) begin
            x_d = '0;
            if (y_q == V_LAST) begin
              y_d = '0;
              if (!i_enable) state_d = S_IDLE;
            end else begin
              y_d = y_q + COORD_W'(1);
            end
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode (inactive outside RUN) and strobes.
  // ---------------------------------------------------------------------------
  assign run = (state_q == S_RUN);

  always_comb begin
    vid_c = run && ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
    hs_c  = (run && ({1'b0, x_q} >= H_SYNC_S) && ({1'b0, x_q} < H_SYNC_E)) ? HS_ON : ~HS_ON;
    vs_c  = (run && ({1'b0, y_q} >= V_SYNC_S) && ({1'b0, y_q} < V_SYNC_E)) ? VS_ON : ~VS_ON;
  end

  assign o_line_start  = o_tick && run && (x_q == '0);
  assign o_frame_start = o_tick && run && (x_q == '0) && (y_q == '0);
  assign o_running     = run;
  assign o_x           = x_q;
  assign o_y           = y_q;

  // ---------------------------------------------------------------------------
  // Alignment delay for video_on/hsync/vsync, counted in i_clk cycles.
  // ---------------------------------------------------------------------------
  if (PIPE_DLY == 0) begin : g_no_dly
    assign o_video_on = vid_c;
    assign o_hsync    = hs_c;
    assign o_vsync    = vs_c;
  end else begin : g_dly
    // Each stage carries {video_on, hsync, vsync}.
    logic [2:0] pipe_q [PIPE_DLY];

    // NOTE: unlike a data memory, this short delay line is reset, because its
    // contents are driven straight onto sync pins and must be inactive.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= {1'b0, ~HS_ON, ~VS_ON};
      end else begin
        pipe_q[0] <= {vid_c, hs_c, vs_c};
        for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign o_video_on = pipe_q[PIPE_DLY-1][2];
    assign o_hsync    = pipe_q[PIPE_DLY-1][1];
    assign o_vsync    = pipe_q[PIPE_DLY-1][0];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two small modes keep whole frames short:
//   dut_a: CLK_DIV=4, H 6/2/3/2 (13), V 4/1/2/1 (8), active-low syncs, no delay.
//   dut_b: CLK_DIV=1, H 4/1/2/1 (8),  V 2/1/1/1 (5), active-high syncs, PIPE_DLY=2.
//   Expected observations are keyed by tick number (1 = first tick after
//   reset release) and queued; monitors pop and compare as ticks occur.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b1;
  logic en_b = 1'b1;

  always #5 clk = ~clk;

  logic       tick_a, vid_a, hs_a, vs_a, ls_a, fs_a, run_a;
  logic [3:0] x_a, y_a;
  logic       tick_b, vid_b, hs_b, vs_b, ls_b, fs_b, run_b;
  logic [2:0] x_b, y_b;

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .PIPE_DLY(0), .COORD_W(4)
  ) dut_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_a),
    .o_tick(tick_a), .o_x(x_a), .o_y(y_a),
    .o_video_on(vid_a), .o_hsync(hs_a), .o_vsync(vs_a),
    .o_line_start(ls_a), .o_frame_start(fs_a), .o_running(run_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .PIPE_DLY(2), .COORD_W(3)
  ) dut_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en_b),
    .o_tick(tick_b), .o_x(x_b), .o_y(y_b),
    .o_video_on(vid_b), .o_hsync(hs_b), .o_vsync(vs_b),
    .o_line_start(ls_b), .o_frame_start(fs_b), .o_running(run_b)
  );

  // flags field order: {run, video_on, hsync, vsync, line_start, frame_start}
  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [5:0] flags;
  } obs_a_t;
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [5:0] flags;
  } obs_b_t;
  typedef struct packed {
    int     tick;
    obs_a_t obs;
  } vec_a_t;
  typedef struct packed {
    int     tick;
    obs_b_t obs;
  } vec_b_t;

  vec_a_t q_a[$];
  vec_b_t q_b[$];

  int checks = 0;
  int errors = 0;
  int tick_cnt_a = 0;
  int tick_cnt_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input int t, input logic [3:0] x, input logic [3:0] y,
                        input logic [5:0] flags);
    vec_a_t v;
    v.tick = t;
    v.obs  = '{x: x, y: y, flags: flags};
    q_a.push_back(v);
  endtask

  task automatic push_b(input int t, input logic [2:0] x, input logic [2:0] y,
                        input logic [5:0] flags);
    vec_b_t v;
    v.tick = t;
    v.obs  = '{x: x, y: y, flags: flags};
    q_b.push_back(v);
  endtask

  // Waits until dut_a has produced tick n; returns at negedge+1 of that tick
  // cycle, so a change to en_a applies to the clock edge that ends tick n.
  task automatic wait_tick_a(input int n);
    int budget;
    budget = 0;
    while (tick_cnt_a < n && budget < 4000) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (tick_cnt_a < n) check($sformatf("wait_tick_%0d_timeout", n), 64'(tick_cnt_a), 64'(n));
  endtask

  // Monitor for dut_a: tick spacing, strobes only on ticks, queued vectors.
  initial begin
    int clk_cnt;
    int last_tick_clk;
    bit have_last;
    vec_a_t v;
    obs_a_t act;
    clk_cnt   = 0;
    have_last = 1'b0;
    last_tick_clk = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_last = 1'b0;
      end else begin
        clk_cnt++;
        if (tick_a) begin
          tick_cnt_a++;
          if (have_last) check("a_tick_period", 64'(clk_cnt - last_tick_clk), 64'd4);
          last_tick_clk = clk_cnt;
          have_last     = 1'b1;
          act = '{x: x_a, y: y_a, flags: {run_a, vid_a, hs_a, vs_a, ls_a, fs_a}};
          while (q_a.size() > 0 && q_a[0].tick <= tick_cnt_a) begin
            v = q_a.pop_front();
            check($sformatf("a_tick%0d {x,y,run,vid,hs,vs,ls,fs}", v.tick), 64'(act), 64'(v.obs));
          end
        end else begin
          check("a_strobe_off_tick", {62'd0, ls_a, fs_a}, 64'd0);
        end
      end
    end
  end

  // Monitor for dut_b (tick every clock).
  initial begin
    vec_b_t v;
    obs_b_t act;
    forever begin
      @(negedge clk);
      if (rst_n && tick_b) begin
        tick_cnt_b++;
        act = '{x: x_b, y: y_b, flags: {run_b, vid_b, hs_b, vs_b, ls_b, fs_b}};
        while (q_b.size() > 0 && q_b[0].tick <= tick_cnt_b) begin
          v = q_b.pop_front();
          check($sformatf("b_tick%0d {x,y,run,vid,hs,vs,ls,fs}", v.tick), 64'(act), 64'(v.obs));
        end
      end
    end
  end

  initial begin
    int rb;

    // ---- dut_a: first frame, stop/restart, restart without gap ----
    push_a(1,   4'd0,  4'd0, 6'b001100);  // IDLE on the first tick
    push_a(2,   4'd0,  4'd0, 6'b111111);  // first RUN tick: frame start
    push_a(7,   4'd5,  4'd0, 6'b111100);  // last visible pixel
    push_a(8,   4'd6,  4'd0, 6'b101100);  // front porch
    push_a(10,  4'd8,  4'd0, 6'b100100);  // hsync first
    push_a(12,  4'd10, 4'd0, 6'b100100);  // hsync last
    push_a(13,  4'd11, 4'd0, 6'b101100);  // back porch
    push_a(14,  4'd12, 4'd0, 6'b101100);  // last x of line
    push_a(15,  4'd0,  4'd1, 6'b111110);  // line start, not frame start
    push_a(46,  4'd5,  4'd3, 6'b111100);  // last visible pixel of frame
    push_a(54,  4'd0,  4'd4, 6'b101110);  // vertical front porch
    push_a(67,  4'd0,  4'd5, 6'b101010);  // vsync first line
    push_a(92,  4'd12, 4'd6, 6'b101000);  // vsync last line, end
    push_a(93,  4'd0,  4'd7, 6'b101110);  // vertical back porch
    push_a(105, 4'd12, 4'd7, 6'b101100);  // last position of frame
    push_a(106, 4'd0,  4'd0, 6'b111111);  // second frame start
    push_a(150, 4'd5,  4'd3, 6'b111100);  // enable low since 120: still running
    push_a(209, 4'd12, 4'd7, 6'b101100);  // frame finishes
    push_a(210, 4'd0,  4'd0, 6'b001100);  // IDLE
    push_a(215, 4'd0,  4'd0, 6'b001100);
    push_a(220, 4'd0,  4'd0, 6'b001100);
    push_a(221, 4'd0,  4'd0, 6'b111111);  // restart: frame start on next tick
    push_a(235, 4'd1,  4'd1, 6'b111100);  // enable low since 230, still running
    push_a(324, 4'd12, 4'd7, 6'b101100);
    push_a(325, 4'd0,  4'd0, 6'b111111);  // re-enabled in time: no gap

    // ---- dut_b: 2-clock delay on decoded outputs, active-high syncs ----
    push_b(1,  3'd0, 3'd0, 6'b000000);
    push_b(2,  3'd0, 3'd0, 6'b100011);
    push_b(3,  3'd1, 3'd0, 6'b100000);
    push_b(4,  3'd2, 3'd0, 6'b110000);
    push_b(7,  3'd5, 3'd0, 6'b110000);
    push_b(8,  3'd6, 3'd0, 6'b100000);  // video_on falls 2 clocks after x=4
    push_b(9,  3'd7, 3'd0, 6'b101000);  // hsync rises 2 clocks after x=5
    push_b(10, 3'd0, 3'd1, 6'b101010);
    push_b(11, 3'd1, 3'd1, 6'b100000);
    push_b(12, 3'd2, 3'd1, 6'b110000);
    push_b(20, 3'd2, 3'd2, 6'b100000);
    push_b(27, 3'd1, 3'd3, 6'b100000);
    push_b(28, 3'd2, 3'd3, 6'b100100);  // vsync line, delayed
    push_b(35, 3'd1, 3'd4, 6'b100100);
    push_b(36, 3'd2, 3'd4, 6'b100000);

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_a {x,y}", {56'd0, x_a, y_a}, 64'd0);
    check("rst_a {tick,run,vid,hs,vs,ls,fs}",
          {57'd0, tick_a, run_a, vid_a, hs_a, vs_a, ls_a, fs_a}, 64'b0001100);
    check("rst_b {tick,run,vid,hs,vs}", {59'd0, tick_b, run_b, vid_b, hs_b, vs_b}, 64'd0);
    rst_n = 1'b1;

    // First tick on clock CLK_DIV after release; dut_b ticks on every clock.
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("a_first_tick_clk%0d", i), 64'(tick_a), 64'(i == 4));
      check($sformatf("b_tick_clk%0d", i), 64'(tick_b), 64'd1);
    end

    wait_tick_a(120);
    en_a = 1'b0;
    wait_tick_a(220);
    en_a = 1'b1;
    wait_tick_a(230);
    en_a = 1'b0;
    wait_tick_a(250);
    en_a = 1'b1;

    // ---- asynchronous reset mid-line, between clock edges ----
    wait_tick_a(330);
    check("pre_reset_x", 64'(x_a), 64'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst {x,y}", {56'd0, x_a, y_a}, 64'd0);
    check("async_rst {tick,run,vid,hs,vs,ls,fs}",
          {57'd0, tick_a, run_a, vid_a, hs_a, vs_a, ls_a, fs_a}, 64'b0001100);
    rb = tick_cnt_a;
    push_a(rb + 1,  4'd0, 4'd0, 6'b001100);
    push_a(rb + 2,  4'd0, 4'd0, 6'b111111);
    push_a(rb + 15, 4'd0, 4'd1, 6'b111110);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("a_restart_tick_clk%0d", i), 64'(tick_a), 64'(i == 4));
    end
    wait_tick_a(rb + 20);

    check("a_vectors_left", 64'(q_a.size()), 64'd0);
    check("b_vectors_left", 64'(q_b.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
